psum_acc_fifo: RTL and testbench

Parametrised partial-sum accumulation FIFO inside each PE, successor to the fixed 64-channel interPE FIFO. It stores per-channel partial sums in arrival order and, on later conv1x1 passes, pops the oldest entry, adds the incoming partial sum lane-wise and either recirculates the result or emits it as a final sum. It sits between the PE MAC array output and the PE output register stage, and adds occupancy flags and sticky error reporting.

---
 rtl/psum_acc_fifo_if.sv | 31 +++
 rtl/psum_acc_fifo.sv | 116 +++++++++++
 tb/tb_psum_acc_fifo.sv | 128 ++++++++++++
 3 files changed

// File: rtl/psum_acc_fifo_if.sv
// Partial-sum FIFO bus: beat inputs from the MAC array, final sums and status back.
// master = upstream MAC array / driver, slave = psum_acc_fifo.
interface psum_acc_fifo_if #(
    parameter int CHN   = 64,
    parameter int DW    = 16,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [CHN*DW-1:0] part_sum;
    logic              part_sum_v;
    logic              first_pass;
    logic              last_pass;
    logic [CHN*DW-1:0] acc_out;
    logic              acc_out_v;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              err_ovf;
    logic              err_udf;

    modport master (
        output part_sum, part_sum_v, first_pass, last_pass,
        input  acc_out, acc_out_v, count, full, empty, err_ovf, err_udf
    );

    modport slave (
        input  part_sum, part_sum_v, first_pass, last_pass,
        output acc_out, acc_out_v, count, full, empty, err_ovf, err_udf
    );
endinterface

// File: rtl/psum_acc_fifo.sv
// Per-PE partial-sum accumulation FIFO: store, recirculate (head+psum) or emit final sums.
// Define PSUM_SAT_EN for signed saturating lane adds; default wraps modulo 2^DW.
module psum_acc_fifo #(
    parameter int CHN   = 64,
    parameter int DW    = 16,
    parameter int DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    psum_acc_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = CHN * DW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          accv_q, accv_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;

    logic [W-1:0]  head, sum, push_data;
    logic          do_push, do_pop, is_full, is_empty;

    function automatic logic signed [DW-1:0] lane_add(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
`ifdef PSUM_SAT_EN
        logic signed [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1])
            lane_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            lane_add = s[DW-1:0];
`else
        lane_add = a + b;
`endif
    endfunction

    assign is_full  = (cnt_q == (AW+1)'(DEPTH));
    assign is_empty = (cnt_q == '0);
    assign head     = mem_q[rp_q];

    always_comb begin
        sum = '0;
        for (int i = 0; i < CHN; i++)
            sum[i*DW +: DW] = lane_add(head[i*DW +: DW], bus.part_sum[i*DW +: DW]);
    end

    always_comb begin
        do_push   = 1'b0;
        do_pop    = 1'b0;
        push_data = bus.part_sum;
        acc_d     = acc_q;
        accv_d    = 1'b0;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        if (bus.part_sum_v) begin
            if (bus.first_pass) begin
                if (is_full) ovf_d   = 1'b1;
                else         do_push = 1'b1;
            end else if (is_empty) begin
                udf_d = 1'b1;
            end else begin
                do_pop = 1'b1;
                if (bus.last_pass) begin
                    acc_d  = sum;
                    accv_d = 1'b1;
                end else begin
                    // Recirculation: head is read before rp moves, so this is legal when full.
                    do_push   = 1'b1;
                    push_data = sum;
                end
            end
        end
        wp_d  = do_push ? wp_q + AW'(1) : wp_q;
        rp_d  = do_pop  ? rp_q + AW'(1) : rp_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            accv_q <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            accv_q <= accv_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= push_data;
    end

    assign bus.acc_out   = acc_q;
    assign bus.acc_out_v = accv_q;
    assign bus.count     = cnt_q;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.err_ovf   = ovf_q;
    assign bus.err_udf   = udf_q;
endmodule

// File: tb/tb_psum_acc_fifo.sv
// Directed bench for psum_acc_fifo at CHN=4, DW=8, DEPTH=4 with hand-computed sums.
module tb_psum_acc_fifo;
    localparam int CHN = 4, DW = 8, DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    psum_acc_fifo_if #(.CHN(CHN), .DW(DW), .DEPTH(DEPTH)) bus ();

    psum_acc_fifo #(.CHN(CHN), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // Drive one beat at the falling edge, then sample 1 ns after the capturing edge.
    task automatic beat(input logic v, fp, lp, input logic [31:0] ps);
        @(negedge clk);
        bus.part_sum_v = v;
        bus.first_pass = fp;
        bus.last_pass  = lp;
        bus.part_sum   = ps;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_sat;
        bus.part_sum_v = 1'b0;
        bus.first_pass = 1'b0;
        bus.last_pass  = 1'b0;
        bus.part_sum   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_count", 64'(bus.count), 0);
        check("rst_empty", 64'(bus.empty), 1);
        check("rst_full",  64'(bus.full),  0);
        check("rst_accv",  64'(bus.acc_out_v), 0);
        check("rst_ovf",   64'(bus.err_ovf), 0);
        check("rst_udf",   64'(bus.err_udf), 0);

        // Beat k carries lanes {k, 2k, 3k, 4k}.
        for (int k = 1; k <= 4; k++)
            beat(1, 1, 0, pack(8'(k), 8'(2*k), 8'(3*k), 8'(4*k)));
        check("fill_count", 64'(bus.count), 4);
        check("fill_full",  64'(bus.full), 1);
        check("fill_empty", 64'(bus.empty), 0);
        beat(1, 1, 0, pack(8'd99, 8'd99, 8'd99, 8'd99));
        check("ovf_count", 64'(bus.count), 4);
        check("ovf_flag",  64'(bus.err_ovf), 1);

        for (int k = 1; k <= 4; k++) begin
            beat(1, 0, 0, pack(8'd10, 8'd10, 8'd10, 8'd10));
            check("recirc_count", 64'(bus.count), 4);
            check("recirc_accv",  64'(bus.acc_out_v), 0);
        end

        for (int k = 1; k <= 4; k++) begin
            beat(1, 0, 1, '0);
            check("emit_accv", 64'(bus.acc_out_v), 1);
            check("emit_data", 64'(bus.acc_out),
                  64'(pack(8'(k+10), 8'(2*k+10), 8'(3*k+10), 8'(4*k+10))));
        end
        check("drain_count", 64'(bus.count), 0);
        check("drain_empty", 64'(bus.empty), 1);
        beat(0, 0, 0, '0);
        check("idle_accv", 64'(bus.acc_out_v), 0);

        beat(1, 0, 1, pack(8'd1, 8'd1, 8'd1, 8'd1));
        check("udf_accv",  64'(bus.acc_out_v), 0);
        check("udf_flag",  64'(bus.err_udf), 1);
        check("udf_count", 64'(bus.count), 0);

        // Lane 0: 100+100, lane 1: -100+-100, lane 2: 5+3, lane 3: 0+0.
        beat(1, 1, 0, pack(8'd100, 8'h9C, 8'd5, 8'd0));
        beat(1, 0, 1, pack(8'd100, 8'h9C, 8'd3, 8'd0));
`ifdef PSUM_SAT_EN
        exp_sat = pack(8'h7F, 8'h80, 8'd8, 8'd0);
`else
        exp_sat = pack(8'hC8, 8'h38, 8'd8, 8'd0);
`endif
        check("sat_accv", 64'(bus.acc_out_v), 1);
        check("sat_data", 64'(bus.acc_out), 64'(exp_sat));

        for (int k = 1; k <= 4; k++)
            beat(1, 1, 0, pack(8'(k), 8'(k), 8'(k), 8'(k)));
        beat(1, 0, 1, '0);
        check("pre_rst_count", 64'(bus.count), 3);
        check("pre_rst_accv",  64'(bus.acc_out_v), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_count", 64'(bus.count), 0);
        check("mid_rst_accv",  64'(bus.acc_out_v), 0);
        check("mid_rst_empty", 64'(bus.empty), 1);
        check("mid_rst_ovf",   64'(bus.err_ovf), 0);
        check("mid_rst_udf",   64'(bus.err_udf), 0);
        bus.part_sum_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        beat(1, 1, 0, pack(8'd1, 8'd2, 8'd3, 8'd4));
        beat(1, 0, 1, pack(8'd5, 8'd5, 8'd5, 8'd5));
        check("post_rst_accv",  64'(bus.acc_out_v), 1);
        check("post_rst_data",  64'(bus.acc_out), 64'(pack(8'd6, 8'd7, 8'd8, 8'd9)));
        check("post_rst_count", 64'(bus.count), 0);
        beat(0, 0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
